// File: rtl/arb_rr_3to8_pkg.sv
`default_nettype none
`include "arb_defs.vh"
// ============================================================================
// Module   : arb_rr_3to8_pkg
// Purpose  : Shared types, constants and the round-robin search function.
// Revision : 1.0 - initial release
// ============================================================================
package arb_rr_3to8_pkg;

  localparam int c_NUM_REQ = 8;

  typedef logic [2:0] idx_t;

  localparam logic [0:0] c_ST_IDLE  = `ARB_ST_IDLE;
  localparam logic [0:0] c_ST_GRANT = `ARB_ST_GRANT;
  localparam idx_t       c_PTR_RST  = `ARB_PTR_RST;

  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;

  // Rotate so index last+1 lands on bit 0, take the lowest set bit, rotate back.
  function automatic pick_t rr_pick(input logic [c_NUM_REQ-1:0] req, input idx_t last);
    logic [c_NUM_REQ-1:0] rot;
    idx_t                 base;
    pick_t                p;
    base    = last + 3'd1;
    p.found = 1'b0;
    p.idx   = base;
    for (int i = 0; i < c_NUM_REQ; i++) begin
      rot[i] = req[base + 3'(i)];
    end
    for (int i = c_NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        p.found = 1'b1;
        p.idx   = base + 3'(i);
      end
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_defs.vh
// Shared arbiter encodings: FSM state values and the reset value of the priority pointer.
`ifndef ARB_DEFS_VH
`define ARB_DEFS_VH

`define ARB_ST_IDLE  1'b0
`define ARB_ST_GRANT 1'b1
`define ARB_PTR_RST  3'd7

`endif

// File: rtl/dec3to8_en.sv
`default_nettype none
// ============================================================================
// Module   : dec3to8_en
// Purpose  : Combinational one-hot 3-to-8 decoder with enable.
// Revision : 1.0 - initial release
// ============================================================================
module dec3to8_en (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign y[i] = en && (sel == 3'(i));
  end

endmodule
`default_nettype wire

// File: rtl/arb_rr_3to8.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr_3to8
// Purpose  : Eight-requester round-robin arbiter with hold timeout, driving a
//            one-hot grant through a 3-to-8 decoder.
// Revision : 1.0 - initial release
// ============================================================================
module arb_rr_3to8
  import arb_rr_3to8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] grant_idx,
  output logic [7:0] grant,
  output logic       grant_valid,
  output logic       preempt
);

  localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0] r_state;
  idx_t       r_last;
  logic [7:0] r_hold_cnt;
  idx_t       r_grant_idx;
  logic       r_grant_valid;
  logic       r_preempt;

  pick_t      w_pick;
  logic       w_owner_req;
  logic       w_timeout;
  logic       w_arb;

  always_comb begin
    w_pick      = rr_pick(req, r_last);
    w_owner_req = req[r_grant_idx];
    // A timeout only counts while the owner still requests; a simultaneous drop is a release.
    w_timeout   = (r_state == c_ST_GRANT) && w_owner_req && (r_hold_cnt == c_HOLD_LAST);
    w_arb       = (r_state == c_ST_IDLE) || !w_owner_req || w_timeout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_ST_IDLE;
      r_last        <= c_PTR_RST;
      r_hold_cnt    <= 8'd0;
      r_grant_idx   <= 3'd0;
      r_grant_valid <= 1'b0;
      r_preempt     <= 1'b0;
    end else begin
      r_preempt <= w_timeout;
      if (w_arb) begin
        r_hold_cnt <= 8'd0;
        if (w_pick.found) begin
          r_state       <= c_ST_GRANT;
          r_grant_idx   <= w_pick.idx;
          r_last        <= w_pick.idx;
          r_grant_valid <= 1'b1;
        end else begin
          r_state       <= c_ST_IDLE;
          r_grant_valid <= 1'b0;
        end
      end else begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end
    end
  end

  dec3to8_en u_dec (
    .en  (r_grant_valid),
    .sel (r_grant_idx),
    .y   (grant)
  );

  assign grant_idx   = r_grant_idx;
  assign grant_valid = r_grant_valid;
  assign preempt     = r_preempt;

endmodule
`default_nettype wire

// File: doc/arb_rr_3to8.md
# arb_rr_3to8

Eight-requester round-robin arbiter that owns the 3-to-8 decoder select path. It picks one requester and registers its 3-bit index. It drives the one-hot grant vector through an internal 3-to-8 decoder stage, and holds the grant until the requester releases or a hold timeout forces rotation. It sits between the requesting units and the shared resource selected by the decoder output.

## Interface
Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held; legal range 2..255.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  8  request vector; bit n = requester n; level-sensitive
- grant_idx  output  3  registered index of the current owner
- grant  output  8  one-hot decode of grant_idx, gated by grant_valid; all zeros when grant_valid=0
- grant_valid  output  1  a grant is active
- preempt  output  1  one-cycle pulse when a grant ends because of the MAX_HOLD timeout

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner = grant_idx.
- Priority pointer `last` (3 bits) holds the index of the most recent winner.
  - Search order is last+1, last+2, … wrapping mod 8, ending at last itself.
  - The first set req bit in that order wins.
- IDLE behaviour:
  - If req != 0: winner → grant_idx, grant_valid=1, last=winner, hold_cnt=0, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, ownership kept (req[grant_idx]=1 and hold_cnt < MAX_HOLD-1): hold_cnt increments.
- GRANT, end of grant (req[grant_idx]=0, or hold_cnt == MAX_HOLD-1):
  - If any req bit is set, the next winner is granted on the same edge. There is no bubble cycle; the search uses the updated `last` order.
  - If no req bit is set: grant_valid=0, go to IDLE.
  - After a timeout, the current owner is searched last. If it is the only requester, it is re-granted and hold_cnt restarts at 0.
- preempt is 1 for exactly the cycle after a timeout-caused end of grant, regardless of who wins next. It is 0 for release-caused ends.
- Arithmetic and widths:
  - hold_cnt is 8 bits unsigned and never exceeds MAX_HOLD-1.
  - Index arithmetic wraps mod 8 (3-bit natural overflow).
- Requests dropped by a non-owner have no effect. A new request while another owner holds the grant waits.

## Timing
- Reset (asynchronous assert) sets:
  - state=IDLE, last=3'd7 (first search starts at index 0), hold_cnt=0
  - grant_idx=0, grant=8'h00, grant_valid=0, preempt=0
- Reset deassertion is sampled synchronously; the first arbitration happens on the first rising edge with rst=0.
- Grant latency: req sampled at edge k → grant/grant_valid valid after edge k. That is one cycle from request to visible grant.
- Release latency: req[owner] low at edge k → new grant, or grant_valid=0, after edge k.
- Maximum continuous ownership is MAX_HOLD cycles; then rotation happens if other requesters exist.
- Reset mid-grant: all outputs clear immediately (asynchronous); the pointer returns to 7.
- grant is combinational from registered grant_idx and grant_valid only. There is no combinational path from req to any output.

## Structure
- Shared include file arb_defs.vh contains:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
  - the reset value of last (ARB_PTR_RST=3'd7)
- Sub-module dec3to8_en: inputs en (1) and sel (3), output y (8). It is a purely combinational one-hot decoder with enable and is instantiated once for grant.
- Round-robin search is implemented as a rotate-priority-rotate-back function inside arb_rr_3to8.

## Test plan
- After reset: grant=00, grant_valid=0, preempt=0, grant_idx=0 → apply req=8'h01 → next cycle grant=8'h01, grant_idx=0.
- Fairness: after reset, hold req=8'hFF and release each owner after 1 cycle → grant sequence 01,02,04,…,80,01.
- Back-to-back handoff: owner 2 granted with req=8'h24; drop bit 2 → next cycle grant=8'h20 with grant_valid continuously 1.
- Timeout (MAX_HOLD=4): req=8'h09 held constant, owner 0 → after 4 cycles of ownership preempt=1 for 1 cycle, grant=8'h08.
- Timeout with sole requester: req=8'h10 constant, MAX_HOLD=4 → preempt pulses every 4 cycles and grant stays 8'h10 without a gap.
- Reset mid-grant: assert rst between clock edges while grant=8'h40 → grant=00 immediately. After release, req=8'h41 → grant=8'h01 (pointer reset to 7).
